// File: rtl/param_updown_counter_if.sv
// Bus bundle for param_updown_counter: controls in, count and status out.
// The prescale member exists only when PRESCALE_EN is defined.
interface param_updown_counter_if #(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 4
);
   logic             en;
   logic             dir;
   logic             mode;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             clr_ovf;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             at_max;
   logic             at_min;
   logic             ovf;
`ifdef PRESCALE_EN
   logic [PRESCALE_W-1:0] prescale;
`endif

   modport master (
`ifdef PRESCALE_EN
      output prescale,
`endif
      output en, dir, mode, load, load_val, clr_ovf,
      input  count, tc, at_max, at_min, ovf
   );

   modport slave (
`ifdef PRESCALE_EN
      input  prescale,
`endif
      input  en, dir, mode, load, load_val, clr_ovf,
      output count, tc, at_max, at_min, ovf
   );
endinterface

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with wrap/saturate, parallel load, terminal-count
// pulse and sticky overflow. Optional prescaler enabled by macro PRESCALE_EN.
module param_updown_counter #(
   parameter int          WIDTH      = 8,
   parameter int unsigned MAX_VAL    = (1 << WIDTH) - 1,
   parameter int unsigned RESET_VAL  = 0,
   parameter int          PRESCALE_W = 4
) (
   input logic                    clk,
   input logic                    rst,
   param_updown_counter_if.slave  bus
);
   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] RST_C = WIDTH'(RESET_VAL);

   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             tick;

`ifdef PRESCALE_EN
   logic [PRESCALE_W-1:0] psc_q, psc_d;
   logic [PRESCALE_W-1:0] lim_q, lim_d;
   logic [PRESCALE_W-1:0] lim_eff;

   // A new prescale value is taken only when the divider starts a period.
   assign lim_eff = (psc_q == '0) ? bus.prescale : lim_q;
   assign tick    = (psc_q == lim_eff);

   // Divider next state: cleared on load and tick, advances only while enabled.
   always_comb begin
      psc_d = psc_q;
      lim_d = lim_q;
      if (bus.load) begin
         psc_d = '0;
      end else if (bus.en) begin
         if (tick) begin
            psc_d = '0;
         end else begin
            psc_d = psc_q + 1'b1;
            if (psc_q == '0) lim_d = bus.prescale;
         end
      end
   end

   // Divider registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         psc_q <= '0;
         lim_q <= '0;
      end else begin
         psc_q <= psc_d;
         lim_q <= lim_d;
      end
   end
`else
   assign tick = 1'b1;
`endif

   // Counter next state: load beats step beats hold; boundary handling per mode.
   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      ovf_d   = bus.clr_ovf ? 1'b0 : ovf_q;
      if (bus.load) begin
         count_d = (bus.load_val > MAX_C) ? MAX_C : bus.load_val;
      end else if (bus.en && tick) begin
         if (!bus.dir) begin
            if (count_q >= MAX_C) begin
               ovf_d = 1'b1;
               if (!bus.mode) begin
                  count_d = '0;
                  tc_d    = 1'b1;
               end else begin
                  count_d = MAX_C;
               end
            end else begin
               count_d = count_q + 1'b1;
            end
         end else begin
            if (count_q == '0) begin
               ovf_d = 1'b1;
               if (!bus.mode) begin
                  count_d = MAX_C;
                  tc_d    = 1'b1;
               end else begin
                  count_d = '0;
               end
            end else begin
               count_d = count_q - 1'b1;
            end
         end
      end
   end

   // Count and status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= RST_C;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.count  = count_q;
   assign bus.tc     = tc_q;
   assign bus.ovf    = ovf_q;
   assign bus.at_max = (count_q == MAX_C);
   assign bus.at_min = (count_q == '0);
endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: three instances (MAX 255, 9, 100).
module tb_param_updown_counter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   param_updown_counter_if #(.WIDTH(8)) ia ();
   param_updown_counter_if #(.WIDTH(8)) ib ();
   param_updown_counter_if #(.WIDTH(8)) ic ();

   param_updown_counter #(.WIDTH(8))                u_a (.clk(clk), .rst(rst), .bus(ia));
   param_updown_counter #(.WIDTH(8), .MAX_VAL(9))   u_b (.clk(clk), .rst(rst), .bus(ib));
   param_updown_counter #(.WIDTH(8), .MAX_VAL(100)) u_c (.clk(clk), .rst(rst), .bus(ic));

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic edge_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      ia.en = 0; ia.dir = 0; ia.mode = 0; ia.load = 0; ia.load_val = 0; ia.clr_ovf = 0;
      ib.en = 0; ib.dir = 0; ib.mode = 0; ib.load = 0; ib.load_val = 0; ib.clr_ovf = 0;
      ic.en = 0; ic.dir = 0; ic.mode = 0; ic.load = 0; ic.load_val = 0; ic.clr_ovf = 0;
`ifdef PRESCALE_EN
      ia.prescale = 0; ib.prescale = 0; ic.prescale = 0;
`endif
      @(negedge clk);
      check("rst_count", ia.count, 0);
      check("rst_tc", ia.tc, 0);
      check("rst_ovf", ia.ovf, 0);
      check("rst_at_min", ia.at_min, 1);
      check("rst_at_max", ia.at_max, 0);
      rst = 0;

      // Full-range wrap on instance A, then load keeps ovf, then async reset mid-run.
      ia.load = 1; ia.load_val = 8'hFE; ia.en = 1;
      edge_n(1);
      check("a_load_fe", ia.count, 8'hFE);
      ia.load = 0;
      edge_n(1);
      check("a_ff", ia.count, 8'hFF);
      check("a_at_max", ia.at_max, 1);
      edge_n(1);
      check("a_wrap_cnt", ia.count, 0);
      check("a_wrap_tc", ia.tc, 1);
      check("a_wrap_ovf", ia.ovf, 1);
      edge_n(1);
      check("a_post_wrap_tc", ia.tc, 0);
      check("a_post_wrap_cnt", ia.count, 1);
      ia.load = 1; ia.load_val = 8'h37;
      edge_n(1);
      check("a_load_37", ia.count, 8'h37);
      check("a_load_keeps_ovf", ia.ovf, 1);
      ia.load = 0;
      edge_n(1);
      check("a_run_38", ia.count, 8'h38);
      #2 rst = 1;
      #1;
      check("a_async_rst_cnt", ia.count, 0);
      check("a_async_rst_ovf", ia.ovf, 0);
      check("a_async_rst_tc", ia.tc, 0);
      ia.en = 0;
      @(negedge clk);
      rst = 0;

      // Hold for five cycles at 0x42, then re-enable.
      ia.load = 1; ia.load_val = 8'h42;
      edge_n(1);
      ia.load = 0;
      for (int i = 0; i < 5; i++) begin
         edge_n(1);
         check("a_hold_cnt", ia.count, 8'h42);
         check("a_hold_tc", ia.tc, 0);
      end
      ia.en = 1;
      edge_n(1);
      check("a_reenable", ia.count, 8'h43);
      ia.en = 0;

      // Instance B (MAX 9): wrap up from 0.
      ib.en = 1;
      for (int i = 1; i <= 10; i++) begin
         edge_n(1);
         check("b_up_cnt", ib.count, i % 10);
         check("b_up_tc", ib.tc, (i == 10) ? 1 : 0);
         check("b_up_at_max", ib.at_max, (i == 9) ? 1 : 0);
         check("b_up_ovf", ib.ovf, (i == 10) ? 1 : 0);
      end
      edge_n(1);
      check("b_after_wrap_cnt", ib.count, 1);
      check("b_after_wrap_tc", ib.tc, 0);
      check("b_ovf_sticky", ib.ovf, 1);
      ib.clr_ovf = 1;
      edge_n(1);
      check("b_clr_ovf", ib.ovf, 0);
      check("b_clr_cnt", ib.count, 2);
      ib.clr_ovf = 0;

      // Saturate down from 2.
      ib.mode = 1; ib.dir = 1; ib.load = 1; ib.load_val = 2;
      edge_n(1);
      check("b_sat_load", ib.count, 2);
      ib.load = 0;
      edge_n(1);
      check("b_sat_1", ib.count, 1);
      edge_n(1);
      check("b_sat_0", ib.count, 0);
      check("b_sat_0_ovf", ib.ovf, 0);
      check("b_sat_at_min", ib.at_min, 1);
      for (int i = 0; i < 2; i++) begin
         edge_n(1);
         check("b_sat_hold", ib.count, 0);
         check("b_sat_tc", ib.tc, 0);
         check("b_sat_ovf", ib.ovf, 1);
      end
      // Switch to wrap while at 0, counting down.
      ib.mode = 0;
      edge_n(1);
      check("b_down_wrap_cnt", ib.count, 9);
      check("b_down_wrap_tc", ib.tc, 1);
      check("b_down_wrap_at_max", ib.at_max, 1);
      ib.en = 0;
      edge_n(1);
      check("b_en0_tc", ib.tc, 0);

      // Instance C (MAX 100): load clamps and wins over step.
      ic.en = 1; ic.load = 1; ic.load_val = 8'hF0;
      edge_n(1);
      check("c_clamp", ic.count, 100);
      check("c_clamp_ovf", ic.ovf, 0);
      ic.load = 0; ic.mode = 1; ic.clr_ovf = 1;
      edge_n(1);
      check("c_sat_cnt", ic.count, 100);
      check("c_set_beats_clr", ic.ovf, 1);
      check("c_sat_tc", ic.tc, 0);
      ic.en = 0;
      edge_n(1);
      check("c_clr_only", ic.ovf, 0);
      ic.clr_ovf = 0; ic.load = 1; ic.load_val = 50;
      edge_n(1);
      check("c_load_50", ic.count, 50);
      ic.load = 0;

`ifdef PRESCALE_EN
      // Prescale 3 on instance A: one step every 4 enabled cycles.
      ia.prescale = 3; ia.load = 1; ia.load_val = 0;
      edge_n(1);
      check("p_load", ia.count, 0);
      ia.load = 0; ia.en = 1;
      for (int i = 1; i <= 8; i++) begin
         edge_n(1);
         check("p_cnt", ia.count, i / 4);
      end
      edge_n(1);
      ia.en = 0;
      edge_n(2);
      ia.en = 1;
      edge_n(2);
      check("p_stretched", ia.count, 2);
      edge_n(1);
      check("p_after_stretch", ia.count, 3);
      ia.en = 0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
Parametrised successor to the 8-bit free-running start/stop counter. Adds a configurable width and modulus, up/down direction, wrap or saturate mode, and a synchronous parallel load. Also provides terminal-count and sticky-overflow status. Drives a user output bus directly or feeds other timing logic in the tile.

Parameters:
WIDTH, 8, counter width in bits (2..16).
MAX_VAL, 2**WIDTH-1, top count value; the count range is 0..MAX_VAL inclusive; must be ≤ 2**WIDTH-1.
RESET_VAL, 0, count value applied on reset; must be ≤ MAX_VAL.
PRESCALE_W, 4, prescaler select width; used only when PRESCALE_EN is defined.

Ports:
clk  input  1  single clock, all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  count enable; 1 = run, 0 = hold.
dir  input  1  0 = count up, 1 = count down.
mode  input  1  0 = wrap at boundary, 1 = saturate at boundary.
load  input  1  synchronous parallel load strobe.
load_val  input  WIDTH  value loaded when load=1.
clr_ovf  input  1  synchronous clear of the sticky ovf flag.
count  output  WIDTH  current count, registered.
tc  output  1  registered terminal-count pulse, one cycle wide.
at_max  output  1  combinational, count == MAX_VAL.
at_min  output  1  combinational, count == 0.
ovf  output  1  sticky flag: a boundary event occurred.

Behaviour:
- Reset (rst=1, asynchronous, any time including mid-count): count=RESET_VAL, tc=0, ovf=0, prescaler=0. at_max and at_min reflect RESET_VAL.
- Per-edge priority: rst > load > step > hold.
- load=1: count <= min(load_val, MAX_VAL), ignoring en, dir and mode. tc <= 0. Prescaler cleared. ovf is unchanged, except that clr_ovf still applies.
- Step occurs when en=1, load=0, and the prescaler tick is true (tick is always true without PRESCALE_EN). One step per tick.
- Up, count < MAX_VAL: count+1.
- Up, count == MAX_VAL: mode 0 gives count <= 0, tc <= 1, ovf set. Mode 1 gives count held at MAX_VAL, tc <= 0, ovf set.
- Down, count > 0: count-1.
- Down, count == 0: mode 0 gives count <= MAX_VAL, tc <= 1, ovf set. Mode 1 gives count held at 0, tc <= 0, ovf set.
- tc is high for exactly the one cycle after a wrap step, i.e. coincident with the first post-wrap count value. It is 0 on every other cycle.
- ovf: sticky until clr_ovf=1. If a set event and clr_ovf occur on the same edge, set wins and ovf=1.
- Changing dir or mode while running takes effect on the next step. No glitch or extra step results.
- en=0: count, tc=0 and the prescaler all hold.
- Arithmetic is unsigned and WIDTH bits. No intermediate value may exceed MAX_VAL, including when MAX_VAL < 2**WIDTH-1.
- Latency: count changes one clk after the qualifying edge. Status flags follow the same edge.

Optional Feature:
Macro PRESCALE_EN.
- Defined: adds input port prescale [PRESCALE_W-1:0] and an internal PRESCALE_W-bit divider.
  - The tick is true on every (prescale+1)-th enabled cycle. prescale=0 gives a step every enabled cycle.
  - The divider advances only when en=1. It clears on rst, on load, and on each tick.
  - A change to prescale applies from the next divider reload.
- Undefined: no prescale port, no divider, and tick is constantly 1.

Test Plan:
- Reset mid-run: WIDTH=8, running up at count=0x37, assert rst asynchronously between edges → count=0x00 immediately, tc=0, ovf=0.
- Wrap up: MAX_VAL=9, mode=0, dir=0, en=1 from 0 → 0..9, 0 sequence; tc=1 only in the cycle count=0 after 9; ovf=1 and stays 1 until clr_ovf.
- Saturate down: MAX_VAL=9, mode=1, dir=1, load 2 → 2, 1, 0, 0, 0; tc never asserted; ovf=1 on the first held 0; at_min=1.
- Load priority and clamp: en=1, dir=0, load=1 with load_val=0xF0 and MAX_VAL=100 → count=100 next cycle, no step that cycle. clr_ovf on the same edge as a saturation event → ovf=1.
- Hold: en=0 for 5 cycles at count=0x42 → count stays 0x42, tc=0. Re-enable → 0x43 on the next edge.
- PRESCALE_EN: prescale=3, en=1 from 0 → count increments every 4th cycle (0 at cycles 0-3, 1 at cycles 4-7, ...). en=0 for 2 cycles mid-period extends that period by 2 cycles.
